counter_io_bridge: RTL and testbench
====================================

# counter_io_bridge

Memory-mapped bus responder that sits between the CPU data bus and the three-channel counter/timer peripheral. It decodes CPU accesses to the counter window, turns writes into one-cycle `counter_we` / `counter_ch` / `counter_val` strobes, and answers reads from shadow registers. It also synchronises the three counter `OUT` lines, latches their rising edges as interrupt-pending bits and drives a single level interrupt to the CPU.

## Interface
- `BASE_ADDR`, default `32'hF000_0000`: window base; a hit is `bus_addr[31:8] == BASE_ADDR[31:8]`.
- `clk` in 1: system clock; the only clock in the block.
- `rst` in 1: reset, synchronous, active-low.
- `bus_req` in 1: access request; held by the CPU until `bus_ack`.
- `bus_we` in 1: 1 = write, 0 = read; stable while `bus_req` is high.
- `bus_addr` in 32: byte address; `[1:0]` ignored; offset = `[7:0]`.
- `bus_wdata` in 32: write data.
- `bus_rdata` out 32: read data; valid only in the `bus_ack` cycle, 0 otherwise.
- `bus_ack` out 1: one-cycle completion pulse.
- `counter_we` out 1: one-cycle write strobe to the counter.
- `counter_ch` out 2: channel select (3 = control word).
- `counter_val` out 32: value presented with `counter_we`.
- `counter0_OUT`, `counter1_OUT`, `counter2_OUT` in 1 each: counter outputs; these are asynchronous to `clk`.
- `counter_irq` out 1: registered interrupt request.

## Operation
Offset map:
- 0x00 / 0x04 / 0x08: channel 0/1/2 lock value, R/W; a read returns the shadow of the last written value.
- 0x0C: control word, R/W; `counter_val[23:0]` is meaningful; the shadow keeps only `[23:0]` and reads as `{8'h00, ctrl}`.
- 0x10: status, RO; `[2:0]` = synchronised OUT levels, `[6:4]` = pending bits.
- 0x14: IRQ enable, R/W, `[2:0]`.
- 0x18: pending, W1C, `[2:0]`.
- Any other in-window offset: acked, read returns 0, write has no effect.

Access state machine: IDLE, WR, ACK, REL.
- IDLE, `bus_req` and hit and write to 0x00–0x0C: latch address and data, go to WR.
- IDLE, any other hit: go to ACK.
- WR: assert `counter_we` with `counter_ch = offset[3:2]` and `counter_val = wdata`; update the shadow register; go to ACK.
- ACK: assert `bus_ack`; drive `bus_rdata` for reads; perform writes to 0x14 and 0x18; go to REL.
- REL: wait for `bus_req` low, then go to IDLE. This prevents a held request from being serviced twice.
- A miss (out of window) never leaves IDLE and is never acked.

Interrupt path:
- Each OUT line passes through a 2-flop synchroniser followed by a previous-value flop.
- A 0→1 edge sets `pending[i]`.
- A W1C write to 0x18 clears the written bits. A set in the same cycle wins over the clear.
- `counter_irq <= |(pending & enable)`.

## Timing
- Request sampled in cycle N:
  - Write to 0x00–0x0C: `counter_we` in N+1, `bus_ack` in N+2.
  - All other hits: `bus_ack` and `bus_rdata` in N+1.
- Earliest next acceptance is 2 cycles after `bus_req` falls (REL, then IDLE).
- OUT edge to `pending` set: 3 cycles. OUT edge to `counter_irq`: 4 cycles.
- Reset values: all outputs 0, shadows 0, enable 0, pending 0, synchroniser flops 0, state IDLE.
- Reset mid-access: the access is dropped with no ack. A `counter_we` that is in flight is deasserted the next cycle.
- A pending bit that is already set ignores further edges; there is no counting.

## Configuration
- `COUNTER_IO_IRQ_EN` defined: synchronisers, pending, enable and `counter_irq` are implemented as described above.
- Not defined:
  - `counter_irq` is tied to 0.
  - 0x14 and 0x18 read 0 and ignore writes.
  - Status `[6:4]` reads 0.
  - Status `[2:0]` still reports the synchronised levels.

## Structure
- Package `counter_io_pkg` holds:
  - the offset constants `OFF_CH0`, `OFF_CH1`, `OFF_CH2`, `OFF_CTRL`, `OFF_STAT`, `OFF_IEN`, `OFF_PEND`;
  - the state enum (IDLE, WR, ACK, REL);
  - the channel-select width.
- Sub-module `sync_edge_det`: 2-flop synchroniser plus rising-edge pulse, instantiated three times (only under `COUNTER_IO_IRQ_EN`, except for the level synchronisers).

## Test plan
- Write `0x0000_1234` to `0xF000_0004` → `counter_we` = 1 for exactly one cycle with `counter_ch` = 1 and `counter_val` = `0x1234`; `bus_ack` follows one cycle later; a read of the same address returns `0x0000_1234`.
- Write `0xFFAB_CDEF` to `0xF000_000C` → `counter_ch` = 3; a read returns `0x00AB_CDEF`.
- Access to `0xE000_0000` → no `bus_ack` and no `counter_we` for 20 cycles. Access to `0xF000_0040` → acked, read returns 0.
- Hold `bus_req` high for 10 cycles on a single write → exactly one `counter_we` and one `bus_ack`.
- Enable = `3'b101`, pulse `counter2_OUT` → pending[2] set 3 cycles later, `counter_irq` = 1 the following cycle. W1C of `0x4` → irq drops. A W1C coinciding with a new edge → pending stays 1.
- Assert reset during WR → `counter_we` and `bus_ack` are 0 the next cycle; shadows, enable and pending all read 0 afterwards.

Source files
------------

// File: rtl/counter_io_pkg.sv
// ============================================================================
//  Module      : counter_io_pkg
//  Description : Shared constants for the counter/timer bus bridge: register
//                offsets, access-FSM state encoding, channel-select width.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package counter_io_pkg;

    // Channel-select width; code 3 addresses the control word.
    localparam int CH_W = 2;

    // Byte offsets inside the 256-byte window.
    localparam logic [7:0] OFF_CH0  = 8'h00;
    localparam logic [7:0] OFF_CH1  = 8'h04;
    localparam logic [7:0] OFF_CH2  = 8'h08;
    localparam logic [7:0] OFF_CTRL = 8'h0C;
    localparam logic [7:0] OFF_STAT = 8'h10;
    localparam logic [7:0] OFF_IEN  = 8'h14;
    localparam logic [7:0] OFF_PEND = 8'h18;

    // Access state machine encoding (IDLE, WR, ACK, REL).
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_WR   = 2'd1;
    localparam state_t ST_ACK  = 2'd2;
    localparam state_t ST_REL  = 2'd3;

endpackage

`default_nettype wire

// File: rtl/counter_io_bridge_if.sv
// ============================================================================
//  Module      : counter_io_bridge_if
//  Description : CPU data-bus request/acknowledge signals seen by the bridge.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface counter_io_bridge_if;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;

    // CPU side
    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ack
    );

    // Bridge side
    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ack
    );
endinterface

`default_nettype wire

// File: rtl/sync_edge_det.sv
// ============================================================================
//  Module      : sync_edge_det
//  Description : Two-flop synchroniser for an asynchronous level, followed by
//                a previous-value flop giving a one-cycle rising-edge pulse.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_edge_det (
    input  wire logic clk,
    input  wire logic rst,       // synchronous, active-low
    input  wire logic i_async,
    output logic      o_level,
    output logic      o_rise
);

    logic r_s1;
    logic r_s2;
    logic r_prev;

    // Synchroniser chain plus history flop for edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1   <= 1'b0;
            r_s2   <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_s1   <= i_async;
            r_s2   <= r_s1;
            r_prev <= r_s2;
        end
    end

    assign o_level = r_s2;
    assign o_rise  = r_s2 & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/counter_io_bridge.sv
// ============================================================================
//  Module      : counter_io_bridge
//  Description : Bus responder for the three-channel counter/timer. Turns
//                writes to the lock/control registers into one-cycle counter
//                strobes, answers reads from shadow registers, and (when
//                COUNTER_IO_IRQ_EN is defined) latches OUT rising edges as
//                pending bits driving a level interrupt.
//  Options     : `define COUNTER_IO_IRQ_EN  -> interrupt path implemented
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module counter_io_bridge
    import counter_io_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'hF000_0000
) (
    input  wire logic               clk,
    input  wire logic               rst,          // synchronous, active-low
    counter_io_bridge_if.slave      bus,
    output logic                    counter_we,
    output logic [CH_W-1:0]         counter_ch,
    output logic [31:0]             counter_val,
    input  wire logic               counter0_OUT,
    input  wire logic               counter1_OUT,
    input  wire logic               counter2_OUT,
    output logic                    counter_irq
);

    state_t      r_state;
    logic [7:0]  r_off;
    logic        r_we;
    logic [31:0] r_wdata;

    logic [31:0] r_sh_ch0;
    logic [31:0] r_sh_ch1;
    logic [31:0] r_sh_ch2;
    logic [23:0] r_sh_ctrl;

    logic        w_hit;
    logic [7:0]  w_off_in;
    logic        w_wr_ch;
    logic [2:0]  w_out_raw;
    logic [2:0]  w_lvl;
    logic [2:0]  w_pend;
    logic [2:0]  w_en;
    logic [31:0] w_rdata;
    logic        w_unused;

    assign w_hit     = (bus.bus_addr[31:8] == BASE_ADDR[31:8]);
    assign w_off_in  = {bus.bus_addr[7:2], 2'b00};
    assign w_wr_ch   = bus.bus_we && (w_off_in <= OFF_CTRL);
    assign w_out_raw = {counter2_OUT, counter1_OUT, counter0_OUT};
    assign w_unused  = &{1'b0, bus.bus_addr[1:0]};

    // Access FSM: capture a hit in IDLE, strobe the counter, ack once, then
    // wait for the CPU to drop its request so a held request is not re-served.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_off   <= 8'h00;
            r_we    <= 1'b0;
            r_wdata <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.bus_req && w_hit) begin
                        r_off   <= w_off_in;
                        r_we    <= bus.bus_we;
                        r_wdata <= bus.bus_wdata;
                        r_state <= w_wr_ch ? ST_WR : ST_ACK;
                    end
                end
                ST_WR:   r_state <= ST_ACK;
                ST_ACK:  r_state <= ST_REL;
                ST_REL:  if (!bus.bus_req) r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Shadow registers track what was last sent to the counter.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sh_ch0  <= 32'h0;
            r_sh_ch1  <= 32'h0;
            r_sh_ch2  <= 32'h0;
            r_sh_ctrl <= 24'h0;
        end else if (r_state == ST_WR) begin
            case (r_off[3:2])
                2'd0:    r_sh_ch0  <= r_wdata;
                2'd1:    r_sh_ch1  <= r_wdata;
                2'd2:    r_sh_ch2  <= r_wdata;
                default: r_sh_ctrl <= r_wdata[23:0];
            endcase
        end
    end

    // Counter strobe is driven only in WR; ch/val are zeroed otherwise.
    assign counter_we  = (r_state == ST_WR);
    assign counter_ch  = counter_we ? r_off[3:2] : '0;
    assign counter_val = counter_we ? r_wdata : 32'h0;

`ifdef COUNTER_IO_IRQ_EN
    logic [2:0] w_rise;
    logic [2:0] w_clr;
    logic       w_ack_wr;
    logic [2:0] r_pend;
    logic [2:0] r_en;
    logic       r_irq;

    for (genvar gi = 0; gi < 3; gi++) begin : g_sync
        sync_edge_det u_sync (
            .clk     (clk),
            .rst     (rst),
            .i_async (w_out_raw[gi]),
            .o_level (w_lvl[gi]),
            .o_rise  (w_rise[gi])
        );
    end

    assign w_ack_wr = (r_state == ST_ACK) && r_we;
    assign w_clr    = (w_ack_wr && (r_off == OFF_PEND)) ? r_wdata[2:0] : 3'b000;

    // Enable/pending registers; a new edge beats a simultaneous W1C clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_en   <= 3'b000;
            r_pend <= 3'b000;
            r_irq  <= 1'b0;
        end else begin
            if (w_ack_wr && (r_off == OFF_IEN)) r_en <= r_wdata[2:0];
            r_pend <= (r_pend & ~w_clr) | w_rise;
            r_irq  <= |(r_pend & r_en);
        end
    end

    assign w_pend      = r_pend;
    assign w_en        = r_en;
    assign counter_irq = r_irq;
`else
    logic [2:0] r_s1;
    logic [2:0] r_s2;

    // Level synchronisers only; no edge history needed without interrupts.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_s1 <= 3'b000;
            r_s2 <= 3'b000;
        end else begin
            r_s1 <= w_out_raw;
            r_s2 <= r_s1;
        end
    end

    assign w_lvl       = r_s2;
    assign w_pend      = 3'b000;
    assign w_en        = 3'b000;
    assign counter_irq = 1'b0;
`endif

    // Read-data mux over the captured offset; unmapped offsets read 0.
    always_comb begin
        w_rdata = 32'h0;
        case (r_off)
            OFF_CH0:  w_rdata = r_sh_ch0;
            OFF_CH1:  w_rdata = r_sh_ch1;
            OFF_CH2:  w_rdata = r_sh_ch2;
            OFF_CTRL: w_rdata = {8'h00, r_sh_ctrl};
            OFF_STAT: w_rdata = {25'h0, w_pend, 1'b0, w_lvl};
            OFF_IEN:  w_rdata = {29'h0, w_en};
            OFF_PEND: w_rdata = {29'h0, w_pend};
            default:  w_rdata = 32'h0;
        endcase
    end

    assign bus.bus_ack   = (r_state == ST_ACK);
    assign bus.bus_rdata = (bus.bus_ack && !r_we) ? w_rdata : 32'h0;

endmodule

`default_nettype wire

// File: tb/tb_counter_io_bridge.sv
// ============================================================================
//  Module      : tb_counter_io_bridge
//  Description : Directed self-checking bench for counter_io_bridge.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_counter_io_bridge;

    logic        clk;
    logic        rst;
    logic        counter_we;
    logic [1:0]  counter_ch;
    logic [31:0] counter_val;
    logic        c0_out, c1_out, c2_out;
    logic        counter_irq;

    int n_chk = 0;
    int n_err = 0;
    int n_we  = 0;
    int n_ack = 0;
    logic [1:0]  last_ch;
    logic [31:0] last_val;

    counter_io_bridge_if bus_if();

    counter_io_bridge #(.BASE_ADDR(32'hF000_0000)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus_if),
        .counter_we   (counter_we),
        .counter_ch   (counter_ch),
        .counter_val  (counter_val),
        .counter0_OUT (c0_out),
        .counter1_OUT (c1_out),
        .counter2_OUT (c2_out),
        .counter_irq  (counter_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters sampled on the falling edge.
    always @(negedge clk) begin
        if (counter_we) begin
            n_we++;
            last_ch  = counter_ch;
            last_val = counter_val;
        end
        if (bus_if.bus_ack) n_ack++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One bus transaction with a bounded wait for bus_ack.
    task automatic access(input logic [31:0] addr, input logic we,
                          input logic [31:0] wdata, output logic [31:0] rdata);
        logic got;
        got   = 1'b0;
        rdata = 32'hDEAD_BEEF;
        bus_if.bus_req   = 1'b1;
        bus_if.bus_we    = we;
        bus_if.bus_addr  = addr;
        bus_if.bus_wdata = wdata;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus_if.bus_ack) begin
                rdata = bus_if.bus_rdata;
                got   = 1'b1;
                break;
            end
        end
        bus_if.bus_req = 1'b0;
        bus_if.bus_we  = 1'b0;
        check("ack_seen", {31'h0, got}, 32'h1);
        tick(2);
    endtask

    logic [31:0] rd;
    int we0, ack0;

    initial begin
        rst = 1'b0;
        bus_if.bus_req = 1'b0; bus_if.bus_we = 1'b0;
        bus_if.bus_addr = 32'h0; bus_if.bus_wdata = 32'h0;
        c0_out = 1'b0; c1_out = 1'b0; c2_out = 1'b0;
        tick(3);
        check("rst_ack",   {31'h0, bus_if.bus_ack}, 32'h0);
        check("rst_rdata", bus_if.bus_rdata, 32'h0);
        check("rst_we",    {31'h0, counter_we}, 32'h0);
        check("rst_val",   counter_val, 32'h0);
        check("rst_irq",   {31'h0, counter_irq}, 32'h0);
        rst = 1'b1;
        tick();

        // Channel-1 write: strobe in N+1, ack in N+2.
        we0 = n_we;
        bus_if.bus_req = 1'b1; bus_if.bus_we = 1'b1;
        bus_if.bus_addr = 32'hF000_0004; bus_if.bus_wdata = 32'h0000_1234;
        tick();
        check("wr_we",    {31'h0, counter_we}, 32'h1);
        check("wr_ch",    {30'h0, counter_ch}, 32'h1);
        check("wr_val",   counter_val, 32'h0000_1234);
        check("wr_noack", {31'h0, bus_if.bus_ack}, 32'h0);
        tick();
        check("wr_we_off", {31'h0, counter_we}, 32'h0);
        check("wr_ack",    {31'h0, bus_if.bus_ack}, 32'h1);
        bus_if.bus_req = 1'b0; bus_if.bus_we = 1'b0;
        tick(2);
        check("wr_we_once", n_we - we0, 32'd1);
        access(32'hF000_0004, 1'b0, 32'h0, rd);
        check("rd_ch1", rd, 32'h0000_1234);

        // Control word keeps only 24 bits.
        access(32'hF000_000C, 1'b1, 32'hFFAB_CDEF, rd);
        check("ctrl_ch",  {30'h0, last_ch}, 32'h3);
        check("ctrl_val", last_val, 32'hFFAB_CDEF);
        access(32'hF000_000C, 1'b0, 32'h0, rd);
        check("rd_ctrl", rd, 32'h00AB_CDEF);

        access(32'hF000_0000, 1'b1, 32'hA5A5_0001, rd);
        access(32'hF000_0008, 1'b1, 32'h5A5A_0002, rd);
        access(32'hF000_0000, 1'b0, 32'h0, rd);
        check("rd_ch0", rd, 32'hA5A5_0001);
        access(32'hF000_0008, 1'b0, 32'h0, rd);
        check("rd_ch2", rd, 32'h5A5A_0002);

        // Out-of-window write must be ignored entirely.
        we0 = n_we; ack0 = n_ack;
        bus_if.bus_req = 1'b1; bus_if.bus_we = 1'b1;
        bus_if.bus_addr = 32'hE000_0000; bus_if.bus_wdata = 32'h1111_1111;
        tick(20);
        bus_if.bus_req = 1'b0; bus_if.bus_we = 1'b0;
        tick();
        check("miss_ack", n_ack - ack0, 32'd0);
        check("miss_we",  n_we - we0, 32'd0);
        access(32'hF000_0040, 1'b0, 32'h0, rd);
        check("rd_unmapped", rd, 32'h0);

        // Held request: exactly one strobe and one ack.
        we0 = n_we; ack0 = n_ack;
        bus_if.bus_req = 1'b1; bus_if.bus_we = 1'b1;
        bus_if.bus_addr = 32'hF000_0008; bus_if.bus_wdata = 32'h0000_0077;
        tick(10);
        bus_if.bus_req = 1'b0; bus_if.bus_we = 1'b0;
        tick(2);
        check("hold_we",  n_we - we0, 32'd1);
        check("hold_ack", n_ack - ack0, 32'd1);

`ifdef COUNTER_IO_IRQ_EN
        access(32'hF000_0014, 1'b1, 32'h5, rd);
        access(32'hF000_0014, 1'b0, 32'h0, rd);
        check("rd_ien", rd, 32'h5);
        c2_out = 1'b1;
        tick(3);
        check("irq_pre", {31'h0, counter_irq}, 32'h0);
        tick();
        check("irq_set", {31'h0, counter_irq}, 32'h1);
        c2_out = 1'b0;
        access(32'hF000_0018, 1'b0, 32'h0, rd);
        check("rd_pend", rd, 32'h4);
        access(32'hF000_0018, 1'b1, 32'h4, rd);
        tick();
        check("irq_clr", {31'h0, counter_irq}, 32'h0);
        access(32'hF000_0018, 1'b0, 32'h0, rd);
        check("pend_clr", rd, 32'h0);
        // Edge arriving in the same cycle as the clear wins.
        c2_out = 1'b1;
        tick();
        access(32'hF000_0018, 1'b1, 32'h4, rd);
        access(32'hF000_0018, 1'b0, 32'h0, rd);
        check("pend_set_wins", rd, 32'h4);
        check("irq_set_wins", {31'h0, counter_irq}, 32'h1);
        c2_out = 1'b0;
        access(32'hF000_0018, 1'b1, 32'h4, rd);
        // Masked channel sets pending but not the interrupt.
        c1_out = 1'b1;
        tick(6);
        c1_out = 1'b0;
        check("irq_masked", {31'h0, counter_irq}, 32'h0);
        access(32'hF000_0018, 1'b0, 32'h0, rd);
        check("pend_masked", rd, 32'h2);
        access(32'hF000_0018, 1'b1, 32'h2, rd);
`else
        access(32'hF000_0014, 1'b1, 32'h7, rd);
        access(32'hF000_0014, 1'b0, 32'h0, rd);
        check("ien_absent", rd, 32'h0);
        c2_out = 1'b1;
        tick(6);
        c2_out = 1'b0;
        check("irq_tied", {31'h0, counter_irq}, 32'h0);
        access(32'hF000_0018, 1'b0, 32'h0, rd);
        check("pend_absent", rd, 32'h0);
`endif

        // Status: synchronised levels (and pending when implemented).
        c0_out = 1'b1; c2_out = 1'b1;
        tick(4);
        access(32'hF000_0010, 1'b0, 32'h0, rd);
`ifdef COUNTER_IO_IRQ_EN
        check("rd_stat", rd, 32'h55);
`else
        check("rd_stat", rd, 32'h05);
`endif
        c0_out = 1'b0; c2_out = 1'b0;
        tick(4);
        access(32'hF000_0018, 1'b1, 32'h7, rd);
        access(32'hF000_0010, 1'b0, 32'h0, rd);
        check("rd_stat_low", rd, 32'h0);

        // Reset while the strobe is in flight.
        ack0 = n_ack;
        bus_if.bus_req = 1'b1; bus_if.bus_we = 1'b1;
        bus_if.bus_addr = 32'hF000_0000; bus_if.bus_wdata = 32'h0000_00AA;
        tick();
        check("rstwr_we", {31'h0, counter_we}, 32'h1);
        rst = 1'b0;
        tick();
        check("rstwr_we_off", {31'h0, counter_we}, 32'h0);
        check("rstwr_noack",  {31'h0, bus_if.bus_ack}, 32'h0);
        bus_if.bus_req = 1'b0; bus_if.bus_we = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        check("rstwr_ack_cnt", n_ack - ack0, 32'd0);
        access(32'hF000_0000, 1'b0, 32'h0, rd);
        check("rst_sh_ch0", rd, 32'h0);
        access(32'hF000_0004, 1'b0, 32'h0, rd);
        check("rst_sh_ch1", rd, 32'h0);
        access(32'hF000_000C, 1'b0, 32'h0, rd);
        check("rst_sh_ctrl", rd, 32'h0);
        access(32'hF000_0014, 1'b0, 32'h0, rd);
        check("rst_ien", rd, 32'h0);
        access(32'hF000_0018, 1'b0, 32'h0, rd);
        check("rst_pend", rd, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
